// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the fetch controller
package fetch_pkg;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {RUN, WAIT, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory read bus plus IF/ID handoff
interface fetch_ctrl_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_valid;
  logic [31:0] imem_rdata;
  logic id_stall;
  logic IFID_valid;
  logic [31:0] IFID_instr;
  logic [31:0] IFID_pc;
  modport master(
    output imem_req, imem_addr, IFID_valid, IFID_instr, IFID_pc,
    input imem_valid, imem_rdata, id_stall
  );
  modport slave(
    input imem_req, imem_addr, IFID_valid, IFID_instr, IFID_pc,
    output imem_valid, imem_rdata, id_stall
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry fetch buffer with synchronous flush and combinational head
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr] <= din;
  end
  assign head = mem[rd];
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC control, single-outstanding imem fetch and IF/ID buffering with EX redirects.
// Define FETCH_PERF_CNT_EN to add the stall/flush performance counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic clk,
  input  logic reset,
  input  logic [31:0] PC,
  output logic PCSrc,
  output logic [31:0] PCMux,
  output logic PCWrite,
  input  logic ex_redirect,
  input  logic [31:0] ex_target,
  fetch_ctrl_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state, state_n;
  logic [CW-1:0] count;
  logic push, pop;
  fetch_entry_t head, din;
  assign din = {PC, bus.imem_rdata};
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .flush(ex_redirect),
    .push(push),
    .pop(pop),
    .din(din),
    .head(head),
    .count(count)
  );
  assign bus.IFID_valid = !reset && count != '0;
  assign bus.IFID_instr = bus.IFID_valid ? head.instr : NOP_INSTR;
  assign bus.IFID_pc = bus.IFID_valid ? head.pc : 32'h0;
  assign bus.imem_addr = PC;
  assign pop = bus.IFID_valid && !bus.id_stall && !ex_redirect;
  always_ff @(posedge clk) begin
    state <= reset ? RUN : state_n;
  end
  always_comb begin
    state_n = state;
    push = 1'b0;
    PCSrc = 1'b0;
    PCMux = 32'h0;
    PCWrite = 1'b0;
    bus.imem_req = 1'b0;
    if (reset) begin
      PCSrc = 1'b1;
      PCMux = RESET_VECTOR;
      PCWrite = 1'b1;
      state_n = RUN;
    end else if (ex_redirect) begin
      PCSrc = 1'b1;
      PCMux = ex_target & ~32'h3;
      PCWrite = 1'b1;
      // an outstanding request whose response has not yet arrived must be drained
      state_n = (state != RUN && !bus.imem_valid) ? DRAIN : RUN;
    end else begin
      case (state)
        RUN: begin
          bus.imem_req = count < CW'(DEPTH);
          state_n = bus.imem_req ? WAIT : RUN;
        end
        WAIT: begin
          push = bus.imem_valid;
          PCWrite = bus.imem_valid;
          state_n = bus.imem_valid ? RUN : WAIT;
        end
        DRAIN: state_n = bus.imem_valid ? RUN : DRAIN;
        default: state_n = RUN;
      endcase
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flushed <= '0;
    end else begin
      if (bus.IFID_valid && bus.id_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (ex_redirect) perf_flushed <= perf_flushed + 32'(count) + 32'(state == WAIT);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven cycle vectors plus hand sequences for redirect/reset corners
module tb_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {
    logic rst, iv;
    logic [31:0] rd;
    logic rdr;
    logic [31:0] tgt;
    logic stall, src;
    logic [31:0] mux;
    logic wr, req;
    logic [31:0] addr;
    logic v;
    logic [31:0] instr, pc;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] PC = 32'hDEAD_BEE0;
  logic PCSrc, PCWrite, ex_redirect = 1'b0;
  logic [31:0] PCMux, ex_target = 32'h0;
  int total = 0;
  int bad = 0;
  fetch_ctrl_if bus();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flushed;
`endif
  fetch_ctrl dut (
    .clk(clk),
    .reset(reset),
    .PC(PC),
    .PCSrc(PCSrc),
    .PCMux(PCMux),
    .PCWrite(PCWrite),
    .ex_redirect(ex_redirect),
    .ex_target(ex_target),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flushed(perf_flushed)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (PCWrite === 1'b1) PC <= PCSrc ? PCMux : PC + 32'd4;
  function automatic vec_t mk(logic rst, logic iv, logic [31:0] rd, logic rdr, logic [31:0] tgt,
                              logic stall, logic src, logic [31:0] mux, logic wr, logic req,
                              logic [31:0] addr, logic v, logic [31:0] instr, logic [31:0] pc);
    vec_t r;
    r.rst = rst; r.iv = iv; r.rd = rd; r.rdr = rdr; r.tgt = tgt; r.stall = stall;
    r.src = src; r.mux = mux; r.wr = wr; r.req = req; r.addr = addr;
    r.v = v; r.instr = v ? instr : NOP; r.pc = v ? pc : 32'h0;
    return r;
  endfunction
  task automatic chk(input int c, input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL cycle %0d %s: got %h want %h", c, nm, got, want);
    end
  endtask
  task automatic step(input vec_t v, input int c);
    @(negedge clk);
    reset = v.rst;
    bus.imem_valid = v.iv;
    bus.imem_rdata = v.rd;
    ex_redirect = v.rdr;
    ex_target = v.tgt;
    bus.id_stall = v.stall;
    #2;
    chk(c, "PCSrc", 32'(PCSrc), 32'(v.src));
    chk(c, "PCMux", PCMux, v.mux);
    chk(c, "PCWrite", 32'(PCWrite), 32'(v.wr));
    chk(c, "imem_req", 32'(bus.imem_req), 32'(v.req));
    if (v.req) chk(c, "imem_addr", bus.imem_addr, v.addr);
    chk(c, "IFID_valid", 32'(bus.IFID_valid), 32'(v.v));
    chk(c, "IFID_instr", bus.IFID_instr, v.instr);
    chk(c, "IFID_pc", bus.IFID_pc, v.pc);
  endtask
  initial begin
    vec_t tbl[$];
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.id_stall = 1'b0;
    // rst iv rd rdr tgt stall | src mux wr req addr v instr pc
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hA000_0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4, 1, 32'hA000_0000, 32'h0));
    tbl.push_back(mk(0, 1, 32'hA000_0004, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h8, 1, 32'hA000_0004, 32'h4));
    tbl.push_back(mk(0, 1, 32'hA000_0008, 0, 0, 1, 0, 0, 1, 0, 0, 1, 32'hA000_0004, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'hA000_0004, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'hA000_0004, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA000_0004, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC, 1, 32'hA000_0008, 32'h8));
    tbl.push_back(mk(0, 1, 32'hA000_000C, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h10, 1, 32'hA000_000C, 32'hC));
    tbl.push_back(mk(0, 0, 0, 1, 32'h103, 0, 1, 32'h100, 1, 0, 0, 1, 32'hA000_000C, 32'hC));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hBAD0_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hB000_0100, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h104, 1, 32'hB000_0100, 32'h100));
    tbl.push_back(mk(0, 1, 32'hBAD0_0002, 1, 32'h300, 0, 1, 32'h300, 1, 0, 0, 1, 32'hB000_0100, 32'h100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
    // back-to-back redirects while a stale response is still outstanding
    step(mk(0, 0, 0, 1, 32'h180, 0, 1, 32'h180, 1, 0, 0, 0, 0, 0), 100);
    step(mk(0, 0, 0, 1, 32'h203, 0, 1, 32'h200, 1, 0, 0, 0, 0, 0), 101);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 102);
    step(mk(0, 1, 32'hBAD0_0003, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 103);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 0), 104);
    step(mk(0, 1, 32'hC000_0200, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 105);
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h204, 1, 32'hC000_0200, 32'h200), 106);
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'hC000_0200, 32'h200), 107);
    // reset in WAIT, then a 3-cycle memory latency; a response seen in RUN is ignored
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), 200);
    step(mk(0, 1, 32'hEEEE_EEEE, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0), 201);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 202);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 203);
    step(mk(0, 1, 32'hD000_0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 204);
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h4, 1, 32'hD000_0000, 32'h0), 205);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
